reg_dump_reader: RTL and testbench

Sequential read-out engine for the 32 x 32-bit register file: on a start request it walks the register addresses from `FIRST_REG` to `LAST_REG`, drives the file's combinational read port, and streams each value out over a valid/ready handshake together with its index. It sits beside the register file as the reader-side counterpart to the write port, and is used for debug dumps, context save and end-of-test checking. It never writes the register file.

---
 rtl/reg_dump_reader.sv | 103 ++++++++++
 tb/tb_reg_dump_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Purpose: walks register addresses FIRST_REG..LAST_REG and streams each value with its index.
// Latency: start sampled at edge N gives the first word valid in cycle N+2; one word per 2 cycles at best.
// Backpressure: a word in SEND holds data/index stable until out_ready; abort drops it untransferred.
module reg_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  readReg,
  input  logic [31:0] readData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  localparam logic [4:0] FIRST_PTR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_PTR  = 5'(LAST_REG);

  state_t      state, stateNext;
  logic [4:0]  ptr, ptrNext;
  logic [31:0] dataNext;
  logic [4:0]  indexNext;

  // State, pointer and captured word registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state     <= stateNext;
      ptr       <= ptrNext;
      out_data  <= dataNext;
      out_index <= indexNext;
    end
  end

  // Next-state logic: abort beats the handshake, and start only counts in IDLE.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    dataNext  = out_data;
    indexNext = out_index;
    case (state)
      IDLE: begin
        if (start) begin
          ptrNext   = FIRST_PTR;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          stateNext = IDLE;
        end else begin
          dataNext  = readData;
          indexNext = ptr;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (out_ready) begin
          if (ptr == LAST_PTR) begin
            stateNext = DONE;
          end else begin
            ptrNext   = ptr + 5'd1;
            stateNext = FETCH;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state only, so no input reaches them combinationally.
  always_comb begin
    readReg   = ptr;
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a register-file model, a scoreboard of accepted words,
// and directed scenarios (full dump, backpressure, single-register range, abort, reset, concurrent write).
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, outReady;
  logic [4:0]  readReg, outIndex;
  logic [31:0] readData, outData;
  logic        outValid, busy, done;

  logic        start5, ready5, abort5;
  logic [4:0]  readReg5, index5;
  logic [31:0] readData5, data5;
  logic        valid5, busy5, done5;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .readReg(readReg), .readData(readData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_index(outIndex),
    .busy(busy), .done(done)
  );

  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .abort(abort5),
    .readReg(readReg5), .readData(readData5),
    .out_valid(valid5), .out_ready(ready5), .out_data(data5), .out_index(index5),
    .busy(busy5), .done(done5)
  );

  // Register file read port: x0 always reads zero.
  always_comb readData  = (readReg  == 5'd0) ? 32'h0 : rf[readReg];
  always_comb readData5 = (readReg5 == 5'd0) ? 32'h0 : rf[readReg5];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard of accepted words, maintained at the transfer edge.
  int          cyc = 0;
  int          doneCount = 0;
  int          lastAcc = -1;
  int          accIdx [$];
  logic [31:0] accData [$];
  int          accCyc [$];
  bit          held = 1'b0;
  logic [31:0] heldData = '0;
  logic [4:0]  heldIdx = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && done) doneCount <= doneCount + 1;
    if (!reset && outValid && outReady && !abort) begin
      accIdx.push_back(int'(outIndex));
      accData.push_back(outData);
      accCyc.push_back(cyc);
    end
    if (reset || !busy) lastAcc <= -1;
    else if (outValid && outReady && !abort) lastAcc <= int'(outIndex);
    held     <= !reset && !abort && outValid && !outReady;
    heldData <= outData;
    heldIdx  <= outIndex;
  end

  // Every valid word must be the next index in sequence and carry that register's content.
  always @(negedge clk) begin
    if (!reset) begin
      if (outValid) begin
        chk("seq_index", 32'(outIndex), 32'(lastAcc + 1));
        chk("word_data", outData, (outIndex == 5'd0) ? 32'h0 : rf[outIndex]);
        chk("busy_with_valid", 32'(busy), 32'd1);
        chk("done_with_valid", 32'(done), 32'd0);
      end
      if (held) begin
        chk("hold_valid", 32'(outValid), 32'd1);
        chk("hold_data", outData, heldData);
        chk("hold_index", 32'(outIndex), 32'(heldIdx));
      end
    end
  end

  // Pulse start, then run until done; doneAt is the cycle count after the start edge.
  task automatic runDump(input bit randReady, input int budget, output int doneAt);
    @(posedge clk); #1;
    start = 1'b1;
    outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    doneAt = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (randReady) outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (n == 1) begin
        chk("lat_fetch_valid", 32'(outValid), 32'd0);
        chk("lat_busy_rise", 32'(busy), 32'd1);
      end
      if (n == 2) chk("lat_first_valid", 32'(outValid), 32'd1);
      if (done) begin
        doneAt = n;
        break;
      end
    end
    if (doneAt < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Start a dump with ready high and stop at the negedge where word idx is presented.
  task automatic runToIndex(input int idx, output bit found);
    @(posedge clk); #1;
    start = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (outValid && int'(outIndex) == idx) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_index", 32'(found), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit hit before summary, required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] fullData [32];
  int d, base, d0;
  bit found;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; outReady = 1'b0;
    start5 = 1'b0; ready5 = 1'b0; abort5 = 1'b0;
    for (int k = 0; k < 32; k++) rf[k] = 32'hA5A50000 + 32'(k);

    // Reset state, with start held during reset
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", outData, 32'd0);
    chk("rst_index", 32'(outIndex), 32'd0);
    chk("rst_readreg", 32'(readReg), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", 32'(busy), 32'd0);

    // Full dump with ready held high
    base = accIdx.size(); d0 = doneCount;
    runDump(1'b0, 200, d);
    chk("full_done_latency", 32'(d), 32'd65);
    chk("full_count", 32'(accIdx.size() - base), 32'd32);
    if (accIdx.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        chk("full_index", 32'(accIdx[base + k]), 32'(k));
        fullData[k] = accData[base + k];
        if (k > 0) chk("full_spacing", 32'(accCyc[base + k] - accCyc[base + k - 1]), 32'd2);
      end
      chk("full_x0", accData[base], 32'h0);
      chk("full_x5", accData[base + 5], 32'hA5A50005);
      chk("full_x31", accData[base + 31], 32'hA5A5001F);
    end
    @(negedge clk);
    chk("full_done_pulse", 32'(done), 32'd0);
    chk("full_busy_fall", 32'(busy), 32'd0);
    chk("full_done_count", 32'(doneCount - d0), 32'd1);

    // Backpressure: random ready, same sequence
    base = accIdx.size(); d0 = doneCount;
    runDump(1'b1, 3000, d);
    @(negedge clk);
    chk("bp_count", 32'(accIdx.size() - base), 32'd32);
    if (accIdx.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        chk("bp_index", 32'(accIdx[base + k]), 32'(k));
        chk("bp_data", accData[base + k], fullData[k]);
      end
    end
    chk("bp_done_count", 32'(doneCount - d0), 32'd1);
    outReady = 1'b0;

    // Single-register range 5..5
    @(posedge clk); #1;
    start5 = 1'b1; ready5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    @(negedge clk);
    chk("r5_fetch_valid", 32'(valid5), 32'd0);
    chk("r5_fetch_busy", 32'(busy5), 32'd1);
    chk("r5_fetch_addr", 32'(readReg5), 32'd5);
    @(negedge clk);
    chk("r5_valid", 32'(valid5), 32'd1);
    chk("r5_index", 32'(index5), 32'd5);
    chk("r5_data", data5, 32'hA5A50005);
    @(negedge clk);
    chk("r5_done", 32'(done5), 32'd1);
    chk("r5_valid_after", 32'(valid5), 32'd0);
    chk("r5_ptr_hold", 32'(readReg5), 32'd5);
    @(negedge clk);
    chk("r5_done_once", 32'(done5), 32'd0);
    chk("r5_idle", 32'(busy5), 32'd0);
    chk("r5_ptr_hold2", 32'(readReg5), 32'd5);
    ready5 = 1'b0;

    // Abort in SEND at index 7 with ready high
    base = accIdx.size(); d0 = doneCount;
    runToIndex(7, found);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_valid", 32'(outValid), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(doneCount - d0), 32'd0);
    chk("abort_words", 32'(accIdx.size() - base), 32'd7);
    base = accIdx.size();
    runDump(1'b0, 200, d);
    chk("restart_latency", 32'(d), 32'd65);
    chk("restart_count", 32'(accIdx.size() - base), 32'd32);
    if (accIdx.size() > base) chk("restart_first", 32'(accIdx[base]), 32'd0);

    // Reset at index 12, start together with reset
    base = accIdx.size();
    runToIndex(12, found);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", outData, 32'd0);
    chk("mid_rst_index", 32'(outIndex), 32'd0);
    chk("mid_rst_readreg", 32'(readReg), 32'd0);
    @(negedge clk);
    chk("mid_rst_start_ignored", 32'(busy), 32'd0);
    chk("mid_rst_words", 32'(accIdx.size() - base), 32'd12);

    // Concurrent write to x20 while index 10 is held, with stray start pulses
    base = accIdx.size(); d0 = doneCount;
    runToIndex(10, found);
    #1;
    outReady = 1'b0; start = 1'b1;
    rf[20] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #1;
    outReady = 1'b1; start = 1'b0;
    d = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 4) begin
        #1 start = 1'b1;
      end
      if (n == 5) begin
        #1 start = 1'b0;
      end
      if (done) begin
        d = n;
        break;
      end
    end
    if (d < 0) chk("cw_done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("cw_idle_after", 32'(busy), 32'd0);
    chk("cw_count", 32'(accIdx.size() - base), 32'd32);
    if (accIdx.size() - base == 32) begin
      chk("cw_x20", accData[base + 20], 32'hDEADBEEF);
      chk("cw_x19", accData[base + 19], 32'hA5A50013);
    end
    chk("cw_done_count", 32'(doneCount - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
